// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory initiator: state encoding, byte lane
// selects and the default memory depth.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Little-endian lanes: lane 0 is bits [7:0], lane 3 is bits [31:24].
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  localparam int DEPTH_WORDS_DEF = 64;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte lane helper: inserts a byte into a word for read-modify-write stores
// and extracts a zero-extended byte for byte loads.
module byte_lane_merge
  import mem_if_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  ins_byte,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  always_comb begin
    merged    = word;
    extracted = '0;
    case (lane)
      LANE0: begin
        merged[7:0]    = ins_byte;
        extracted[7:0] = word[7:0];
      end
      LANE1: begin
        merged[15:8]   = ins_byte;
        extracted[7:0] = word[15:8];
      end
      LANE2: begin
        merged[23:16]  = ins_byte;
        extracted[7:0] = word[23:16];
      end
      default: begin
        merged[31:24]  = ins_byte;
        extracted[7:0] = word[31:24];
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: load/store requests in, single-outstanding access to a
// word-only memory, byte stores done as read-modify-write.
//
// state | meaning
// IDLE  | ready for a request; errors are decided here at accept
// READ  | word address on the bus, read data captured at the closing edge
// WRITE | MemWrite high for exactly this cycle
// RESP  | response held until RspReady
module mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic                  ReqByte,
  input  logic [31:0]           ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspErr,
  output logic [31:0]           MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData
);

  state_t      state;
  logic        write_q;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic [7:0]  byte_data_q;
  logic [31:0] merged;
  logic [31:0] extracted;
  logic        misaligned;
  logic        out_of_range;

  byte_lane_merge u_merge (
    .word      (MemReadData),
    .ins_byte  (byte_data_q),
    .lane      (lane_q),
    .merged    (merged),
    .extracted (extracted)
  );

  assign misaligned   = !ReqByte && (ReqAddr[1:0] != 2'b00);
  assign out_of_range = {2'b00, ReqAddr[31:2]} >= 32'(DEPTH_WORDS);

  // Ready is gated by the reset pin so it reads low for the whole reset window.
  assign ReqReady = (state == IDLE) && RESETn;
  assign RspValid = (state == RESP);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      lane_q       <= 2'b00;
      byte_data_q  <= 8'h00;
      RspData      <= '0;
      RspErr       <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemWrite     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MemWrite <= 1'b0;
          if (ReqValid) begin
            write_q     <= ReqWrite;
            byte_q      <= ReqByte;
            lane_q      <= ReqAddr[1:0];
            byte_data_q <= ReqData[7:0];
            if (misaligned || out_of_range) begin
              RspErr  <= 1'b1;
              RspData <= '0;
              state   <= RESP;
            end else begin
              MemAddress <= {ReqAddr[31:2], 2'b00};
              if (ReqWrite && !ReqByte) begin
                MemWriteData <= ReqData;
                MemWrite     <= 1'b1;
                state        <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (write_q) begin
            MemWriteData <= merged;
            MemWrite     <= 1'b1;
            state        <= WRITE;
          end else begin
            RspErr  <= 1'b0;
            RspData <= byte_q ? extracted : MemReadData;
            state   <= RESP;
          end
        end
        WRITE: begin
          MemWrite <= 1'b0;
          RspErr   <= 1'b0;
          RspData  <= '0;
          state    <= RESP;
        end
        default: begin
          if (RspReady) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural word memory on the Mem* pins, a
// directed vector table, randomized accesses against a reference model, and
// hand-written backpressure and mid-RMW reset sequences.
module tb_mem_access_unit;

  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic        ReqByte;
  logic [31:0] ReqAddr;
  logic [31:0] ReqData;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic [31:0] MemReadData;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_access_unit #(.DEPTH_WORDS(DEPTH), .DATA_WIDTH(32)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqByte      (ReqByte),
    .ReqAddr      (ReqAddr),
    .ReqData      (ReqData),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspData      (RspData),
    .RspErr       (RspErr),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  // Combinational-read, clocked-write word memory.
  assign MemReadData = mem[MemAddress[7:2]];
  always @(posedge CLK) begin
    if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level reference: expected response, latency and write effect.
  function automatic void ref_op(input logic w, input logic b, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rd,
                                 output logic e, output int lat, output int np,
                                 output logic [31:0] wd);
    int idx;
    int sh;
    idx = int'(a >> 2);
    sh  = 8 * int'(a % 4);
    rd  = 0;
    np  = 0;
    wd  = 0;
    e   = (!b && (a % 4 != 0)) || (a / 4 >= DEPTH);
    if (e) begin
      lat = 1;
    end else if (w) begin
      np = 1;
      if (b) begin
        lat = 3;
        wd  = (ref_mem[idx] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end else begin
        lat = 2;
        wd  = d;
      end
      ref_mem[idx] = wd;
    end else begin
      lat = 2;
      rd  = b ? ((ref_mem[idx] >> sh) & 32'hFF) : ref_mem[idx];
    end
  endfunction

  // Issue one request, observe the access, optionally stall the response.
  task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic e, output int lat,
                        output int np, output logic [31:0] wa, output logic [31:0] wd);
    int wait_cnt;
    int k;
    np = 0;
    wa = 0;
    wd = 0;
    ReqWrite = w;
    ReqByte  = b;
    ReqAddr  = a;
    ReqData  = d;
    ReqValid = 1'b1;
    wait_cnt = 0;
    while (!ReqReady && wait_cnt < 10) begin
      @(posedge CLK); #1;
      wait_cnt++;
    end
    if (!ReqReady) chk("req_ready_timeout", {31'b0, ReqReady}, 32'd1);
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    k = 1;
    while (!RspValid && k < 8) begin
      if (MemWrite) begin
        np++;
        wa = MemAddress;
        wd = MemWriteData;
      end
      @(posedge CLK); #1;
      k++;
    end
    if (!RspValid) chk("rsp_valid_timeout", {31'b0, RspValid}, 32'd1);
    if (MemWrite) np++;
    rd  = RspData;
    e   = RspErr;
    lat = k;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      chk("hold_valid", {31'b0, RspValid}, 32'd1);
      chk("hold_data", RspData, rd);
      chk("hold_err", {31'b0, RspErr}, {31'b0, e});
      chk("hold_ready", {31'b0, ReqReady}, 32'd0);
    end
    RspReady = 1'b1;
    @(posedge CLK); #1;
    RspReady = 1'b0;
    chk("ready_after_rsp", {31'b0, ReqReady}, 32'd1);
    chk("valid_after_rsp", {31'b0, RspValid}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_np;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] rd, wa, wd, e_rd, e_wd, a, d;
    logic        e, e_e, w, b;
    int          lat, np, e_lat, e_np;

    vecs[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'h10, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0, 2, 1, 32'h20, 32'h11223344};
    vecs[3]  = '{1'b1, 1'b1, 32'h22,  32'h123456AB, 32'h0,        1'b0, 3, 1, 32'h20, 32'h11AB3344};
    vecs[4]  = '{1'b0, 1'b0, 32'h20,  32'h0,        32'h11AB3344, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h04,  32'hA1B2C3D4, 32'h0,        1'b0, 2, 1, 32'h04, 32'hA1B2C3D4};
    vecs[6]  = '{1'b0, 1'b1, 32'h04,  32'h0,        32'h000000D4, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h05,  32'h0,        32'h000000C3, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h06,  32'h0,        32'h000000B2, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[9]  = '{1'b0, 1'b1, 32'h07,  32'h0,        32'h000000A1, 1'b0, 2, 0, 32'h0,  32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h12,  32'h0,        32'h0,        1'b1, 1, 0, 32'h0,  32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h100, 32'h55555555, 32'h0,        1'b1, 1, 0, 32'h0,  32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'h103, 32'h000000EE, 32'h0,        1'b1, 1, 0, 32'h0,  32'h0};
    vecs[13] = '{1'b1, 1'b1, 32'h07,  32'hFFFFFF5A, 32'h0,        1'b0, 3, 1, 32'h04, 32'h5AB2C3D4};
    vecs[14] = '{1'b0, 1'b0, 32'h04,  32'h0,        32'h5AB2C3D4, 1'b0, 2, 0, 32'h0,  32'h0};

    RESETn   = 1'b0;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqByte  = 1'b0;
    ReqAddr  = '0;
    ReqData  = '0;
    RspReady = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("rst_rsp_valid", {31'b0, RspValid}, 32'd0);
    chk("rst_rsp_err", {31'b0, RspErr}, 32'd0);
    chk("rst_rsp_data", RspData, 32'd0);
    chk("rst_mem_addr", MemAddress, 32'd0);
    chk("rst_mem_wdata", MemWriteData, 32'd0);
    chk("rst_mem_write", {31'b0, MemWrite}, 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("first_idle_ready", {31'b0, ReqReady}, 32'd1);

    // Preload every word so the memory and reference agree everywhere.
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      ref_op(1'b1, 1'b0, 32'(i * 4), d, e_rd, e_e, e_lat, e_np, e_wd);
      do_req(1'b1, 1'b0, 32'(i * 4), d, 0, rd, e, lat, np, wa, wd);
      chk($sformatf("pre%0d_lat", i), 32'(lat), 32'(e_lat));
      chk($sformatf("pre%0d_wd", i), wd, e_wd);
    end

    for (int i = 0; i < 15; i++) begin
      ref_op(vecs[i].wr, vecs[i].bt, vecs[i].addr, vecs[i].data, e_rd, e_e, e_lat, e_np, e_wd);
      do_req(vecs[i].wr, vecs[i].bt, vecs[i].addr, vecs[i].data, 0, rd, e, lat, np, wa, wd);
      chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_pulses", i), 32'(np), 32'(vecs[i].exp_np));
      if (vecs[i].exp_np == 1) begin
        chk($sformatf("vec%0d_waddr", i), wa, vecs[i].exp_wa);
        chk($sformatf("vec%0d_wdata", i), wd, vecs[i].exp_wd);
      end
    end

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(256, 400));
      else a = 32'($urandom_range(0, 255));
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = $urandom;
      ref_op(w, b, a, d, e_rd, e_e, e_lat, e_np, e_wd);
      do_req(w, b, a, d, 0, rd, e, lat, np, wa, wd);
      chk($sformatf("rnd%0d_data", i), rd, e_rd);
      chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, e_e});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_pulses", i), 32'(np), 32'(e_np));
      if (e_np == 1) chk($sformatf("rnd%0d_wdata", i), wd, e_wd);
    end

    // Backpressure: response held for five cycles.
    ref_op(1'b0, 1'b0, 32'h10, 32'h0, e_rd, e_e, e_lat, e_np, e_wd);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 5, rd, e, lat, np, wa, wd);
    chk("bp_data", rd, e_rd);
    chk("bp_lat", 32'(lat), 32'd2);

    // Reset while a byte store sits in READ: no write, no response.
    ref_op(1'b1, 1'b0, 32'h30, 32'h55667788, e_rd, e_e, e_lat, e_np, e_wd);
    do_req(1'b1, 1'b0, 32'h30, 32'h55667788, 0, rd, e, lat, np, wa, wd);
    ReqWrite = 1'b1;
    ReqByte  = 1'b1;
    ReqAddr  = 32'h31;
    ReqData  = 32'h000000CC;
    ReqValid = 1'b1;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    chk("rmw_in_read", {31'b0, RspValid | MemWrite}, 32'd0);
    RESETn = 1'b0;
    #1;
    chk("rmw_rst_mem_write", {31'b0, MemWrite}, 32'd0);
    chk("rmw_rst_rsp_valid", {31'b0, RspValid}, 32'd0);
    chk("rmw_rst_req_ready", {31'b0, ReqReady}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK); #1;
    chk("rmw_rel_ready", {31'b0, ReqReady}, 32'd1);
    chk("rmw_rel_valid", {31'b0, RspValid}, 32'd0);
    chk("rmw_mem_word", mem[12], 32'h55667788);
    ref_op(1'b0, 1'b0, 32'h30, 32'h0, e_rd, e_e, e_lat, e_np, e_wd);
    do_req(1'b0, 1'b0, 32'h30, 32'h0, 0, rd, e, lat, np, wa, wd);
    chk("rmw_reload", rd, e_rd);
    chk("rmw_reload_const", rd, 32'h55667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
